// File: rtl/vc_trigger_sequencer.sv
// Delay-ramp select sequencer: latches t1/t2/t3 requests, grants one burst at a time, then
// forces an all-low guard gap. Define VC_SEQ_RR_EN for round-robin grant (default: t1>t2>t3).
module vc_trigger_sequencer #(
   parameter int unsigned HOLD1   = 394,
   parameter int unsigned HOLD2   = 256,
   parameter int unsigned HOLD3   = 128,
   parameter int unsigned GAP_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic [2:0] req,
   input  logic       abort,
   output logic       t1,
   output logic       t2,
   output logic       t3,
   output logic       busy,
   output logic [1:0] active_id,
   output logic       done
);

   typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

   localparam logic [12:0] Hold1M1 = 13'(HOLD1 - 1);
   localparam logic [12:0] Hold2M1 = 13'(HOLD2 - 1);
   localparam logic [12:0] Hold3M1 = 13'(HOLD3 - 1);
   localparam logic [12:0] GapM1   = 13'(GAP_LEN - 1);

   state_e      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [1:0]  chan_q, chan_d;
   logic [2:0]  pend_q, pend_d;
   logic        done_q, done_d;
   logic [2:0]  active_mask, pend_eff, grant_mask;
   logic [1:0]  grant;

   function automatic logic [12:0] hold_len(input logic [1:0] ch);
      case (ch)
         2'd1:    return Hold1M1;
         2'd2:    return Hold2M1;
         default: return Hold3M1;
      endcase
   endfunction

   // First channel of the search order a, b, c with a pending request; 0 if none.
   function automatic logic [1:0] pick(input logic [2:0] p, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
      if (p[a - 2'd1])      return a;
      else if (p[b - 2'd1]) return b;
      else if (p[c - 2'd1]) return c;
      else                  return 2'd0;
   endfunction

   assign active_mask = {chan_q == 2'd3, chan_q == 2'd2, chan_q == 2'd1};
   // Requests arriving this cycle are visible to a grant made in the same cycle.
   assign pend_eff    = pend_q | (req & ~active_mask);
   assign grant_mask  = {grant == 2'd3, grant == 2'd2, grant == 2'd1};

`ifdef VC_SEQ_RR_EN
   logic [1:0] last_q;

   always_comb begin
      unique case (last_q)
         2'd1:    grant = pick(pend_eff, 2'd2, 2'd3, 2'd1);
         2'd2:    grant = pick(pend_eff, 2'd3, 2'd1, 2'd2);
         default: grant = pick(pend_eff, 2'd1, 2'd2, 2'd3);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 2'd3;
      end else if (!abort && sample_en && state_q == StIdle && grant != 2'd0) begin
         last_q <= grant;
      end
   end
`else
   assign grant = pick(pend_eff, 2'd1, 2'd2, 2'd3);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chan_d  = chan_q;
      pend_d  = pend_eff;
      done_d  = 1'b0;
      if (abort) begin
         state_d = StIdle;
         cnt_d   = 13'd0;
         chan_d  = 2'd0;
         pend_d  = 3'b000;
      end else if (sample_en) begin
         unique case (state_q)
            StIdle: begin
               if (grant != 2'd0) begin
                  pend_d  = pend_eff & ~grant_mask;
                  cnt_d   = hold_len(grant);
                  chan_d  = grant;
                  state_d = StRun;
               end
            end
            StRun: begin
               if (cnt_q != 13'd0) begin
                  cnt_d = cnt_q - 13'd1;
               end else begin
                  chan_d  = 2'd0;
                  done_d  = 1'b1;
                  cnt_d   = GapM1;
                  state_d = StGap;
               end
            end
            StGap: begin
               if (cnt_q == 13'd0) state_d = StIdle;
               else                cnt_d   = cnt_q - 13'd1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 13'd0;
         chan_q  <= 2'd0;
         pend_q  <= 3'b000;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chan_q  <= chan_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
      end
   end

   assign t1        = (chan_q == 2'd1);
   assign t2        = (chan_q == 2'd2);
   assign t3        = (chan_q == 2'd3);
   assign active_id = chan_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

endmodule

// File: tb/tb_vc_trigger_sequencer.sv
// Directed bench for vc_trigger_sequencer: strobes every 4 clocks, a monitor tallies select
// strobes, done pulses and grant order, and scenario checks compare against hand-derived values.
module tb_vc_trigger_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_en;
   logic [2:0] req;
   logic       abort;
   logic       t1, t2, t3, busy, done;
   logic [1:0] active_id;

   int errors = 0;
   int checks = 0;

   // Monitor state; scenario-local tallies are cleared through clr_req.
   logic       clr_req = 1'b0;
   logic       skip_hold = 1'b1;
   logic       se, ab;
   logic [4:0] snap, prev = '0;
   int hi1, hi2, hi3, done_cnt, low_run, min_gap;
   int done_bad = 0, onehot_bad = 0, hold_bad = 0;
   bit seen_burst;
   int order[$];

   vc_trigger_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .req       (req),
      .abort     (abort),
      .t1        (t1),
      .t2        (t2),
      .t3        (t3),
      .busy      (busy),
      .active_id (active_id),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      se = sample_en;
      ab = abort;
      #1;
      snap = {t3, t2, t1, busy, active_id};
      if (clr_req) begin
         hi1 = 0; hi2 = 0; hi3 = 0; done_cnt = 0; low_run = 0; min_gap = 9999;
         seen_burst = 1'b0;
         order.delete();
      end else if (rst_n && !skip_hold) begin
         if (!se && !ab && snap != prev) hold_bad++;
         if (int'(t1) + int'(t2) + int'(t3) > 1) onehot_bad++;
         if (se) begin
            if (t1) hi1++;
            if (t2) hi2++;
            if (t3) hi3++;
            if ({t3, t2, t1} == 3'b000) low_run++;
         end
         if (done) begin
            done_cnt++;
            if ({t3, t2, t1} != 3'b000 || prev[1:0] == 2'd0) done_bad++;
         end
         if (prev[1:0] == 2'd0 && active_id != 2'd0) begin
            order.push_back(int'(active_id));
            if (seen_burst && low_run < min_gap) min_gap = low_run;
            seen_burst = 1'b1;
            low_run = 0;
         end
      end
      prev = snap;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic [2:0] r, input logic a);
      @(negedge clk);
      sample_en = s;
      req = r;
      abort = a;
      @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [2:0] r);
      cyc(1'b1, r, 1'b0);
      repeat (3) cyc(1'b0, 3'b000, 1'b0);
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) strobe(3'b000);
   endtask

   task automatic clear_stats();
      @(negedge clk);
      clr_req = 1'b1;
      @(posedge clk);
      #2;
      clr_req = 1'b0;
   endtask

   function automatic logic [5:0] order_code();
      logic [5:0] code = '0;
      for (int i = 0; i < 3; i++)
         if (i < order.size()) code[5-2*i -: 2] = 2'(order[i]);
      return code;
   endfunction

   function automatic logic [6:0] outs();
      return {t3, t2, t1, busy, active_id, done};
   endfunction

   initial begin
      rst_n = 1'b0;
      sample_en = 1'b0;
      req = 3'b000;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_outs", 32'(outs()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 3'b000, 1'b0);
      skip_hold = 1'b0;
      check_eq("idle_after_rst", 32'(outs()), 32'd0);

      // Single t1 request captured between strobes.
      clear_stats();
      cyc(1'b0, 3'b001, 1'b0);
      check_eq("s1_wait_strobe", 32'(t1), 32'd0);
      strobe(3'b000);
      check_eq("s1_grant_sel", 32'({t3, t2, t1}), 32'b001);
      check_eq("s1_grant_id", 32'(active_id), 32'd1);
      check_eq("s1_grant_busy", 32'(busy), 32'd1);
      strobes(393);
      check_eq("s1_t1_last", 32'(t1), 32'd1);
      strobe(3'b000);
      check_eq("s1_t1_fall", 32'(t1), 32'd0);
      check_eq("s1_gap_busy0", 32'(busy), 32'd1);
      strobes(3);
      check_eq("s1_gap_busy3", 32'(busy), 32'd1);
      strobe(3'b000);
      check_eq("s1_idle_busy", 32'(busy), 32'd0);
      check_eq("s1_hi1", 32'(hi1), 32'd394);
      check_eq("s1_hi23", 32'(hi2 + hi3), 32'd0);
      check_eq("s1_done", 32'(done_cnt), 32'd1);

      // All three requested together.
      clear_stats();
      cyc(1'b0, 3'b111, 1'b0);
      strobes(800);
`ifdef VC_SEQ_RR_EN
      check_eq("s2_order", 32'(order_code()), 32'({2'd2, 2'd3, 2'd1}));
`else
      check_eq("s2_order", 32'(order_code()), 32'({2'd1, 2'd2, 2'd3}));
`endif
      check_eq("s2_nbursts", 32'(order.size()), 32'd3);
      check_eq("s2_hi1", 32'(hi1), 32'd394);
      check_eq("s2_hi2", 32'(hi2), 32'd256);
      check_eq("s2_hi3", 32'(hi3), 32'd128);
      check_eq("s2_done", 32'(done_cnt), 32'd3);
      check_eq("s2_min_gap", 32'(min_gap), 32'd5);

      // Request on the strobe itself; re-request of the active channel is ignored.
      clear_stats();
      strobe(3'b001);
      check_eq("s3_zero_latency", 32'(t1), 32'd1);
      strobes(10);
      cyc(1'b0, 3'b001, 1'b0);
      cyc(1'b0, 3'b010, 1'b0);
      strobes(670);
      check_eq("s3_order", 32'(order_code()), 32'({2'd1, 2'd2, 2'd0}));
      check_eq("s3_hi1", 32'(hi1), 32'd394);
      check_eq("s3_hi2", 32'(hi2), 32'd256);
      check_eq("s3_done", 32'(done_cnt), 32'd2);
      check_eq("s3_min_gap", 32'(min_gap), 32'd5);

      // Abort mid t2 burst with t3 pending.
      clear_stats();
      strobe(3'b010);
      check_eq("s4_grant_id", 32'(active_id), 32'd2);
      cyc(1'b0, 3'b100, 1'b0);
      strobes(99);
      check_eq("s4_t2_before", 32'(t2), 32'd1);
      cyc(1'b1, 3'b000, 1'b1);
      check_eq("s4_abort_outs", 32'(outs()), 32'd0);
      cyc(1'b0, 3'b000, 1'b0);
      strobes(500);
      check_eq("s4_hi2", 32'(hi2), 32'd100);
      check_eq("s4_hi3", 32'(hi3), 32'd0);
      check_eq("s4_done", 32'(done_cnt), 32'd0);
      check_eq("s4_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid t3 burst, then a normal t1 burst.
      clear_stats();
      strobe(3'b100);
      strobes(49);
      check_eq("s5_t3_before", 32'(t3), 32'd1);
      @(negedge clk);
      skip_hold = 1'b1;
      rst_n = 1'b0;
      #1;
      check_eq("s5_async_rst", 32'(outs()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 3'b000, 1'b0);
      skip_hold = 1'b0;
      clear_stats();
      cyc(1'b0, 3'b001, 1'b0);
      strobes(400);
      check_eq("s5_order", 32'(order_code()), 32'({2'd1, 2'd0, 2'd0}));
      check_eq("s5_hi1", 32'(hi1), 32'd394);
      check_eq("s5_hi3", 32'(hi3), 32'd0);
      check_eq("s5_done", 32'(done_cnt), 32'd1);

      check_eq("hold_without_strobe", 32'(hold_bad), 32'd0);
      check_eq("onehot", 32'(onehot_bad), 32'd0);
      check_eq("done_at_fall", 32'(done_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
